// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for asynchronous 4-phase request lines with per-line synchronizers.
// Optional forced-revocation hold limit compiled in with `define ARB_TIMEOUT_EN.

module async_req_arbiter_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

module async_req_arbiter #(
    parameter int N_REQ          = 4,
    parameter int STAGES         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     timeout
);

    localparam int             IW   = $clog2(N_REQ);
    localparam logic [IW:0]    NW   = (IW+1)'(N_REQ);
    localparam logic [IW-1:0]  LAST = IW'(N_REQ-1);

    generate
        if (N_REQ < 2 || N_REQ > 8 || STAGES < 2 ||
            TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
            $error("async_req_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] cand;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    sel;
    logic             found;
    logic [IW:0]      sum;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        async_req_arbiter_sync #(.STAGES(STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req[i]),
            .q   (req_s[i])
        );
    end

`ifdef ARB_TIMEOUT_EN
    logic [N_REQ-1:0] mask;
    logic [7:0]       hold_cnt;
    logic             timeout_r;

    assign cand    = req_s & ~mask;
    assign timeout = timeout_r;
`else
    assign cand    = req_s;
    assign timeout = 1'b0;
`endif

    // Search ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit is the winner.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= NW) sum = sum - NW;
            if (!found && cand[sum[IW-1:0]]) begin
                found = 1'b1;
                sel   = sum[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= LAST;
`ifdef ARB_TIMEOUT_EN
            mask      <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_r <= 1'b0;
            // A masked requester becomes eligible again once it drops its request.
            mask      <= mask & req_s;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                        gnt_idx   <= sel;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req_s[gnt_idx]) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx;
                        state     <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == 8'(TIMEOUT_CYCLES-1)) begin
                        gnt            <= '0;
                        gnt_valid      <= 1'b0;
                        ptr            <= gnt_idx;
                        state          <= IDLE;
                        timeout_r      <= 1'b1;
                        mask[gnt_idx]  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
